// File: rtl/io_supply_pkg.sv
// Shared types and widths for the pad supply sequencer.
package io_supply_pkg;
    localparam int TMO_W = 16;
    localparam int DOM_W = 3;

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_WAIT,
        S_UP_SETTLE,
        S_ON,
        S_DN_SETTLE,
        S_FAULT
    } state_e;
endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser, width-parameterised; 2-cycle latency, no flow control.
module io_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/io_supply_sequencer.sv
// Thermometer power-up/down sequencer for pad supply domains; optional ON-state pgood monitor via SUPPLY_SEQ_MON_EN.
// Outputs registered, decisions on pgood 2 cycles late through the synchroniser; no handshake, start/stop are levels.
module io_supply_sequencer
    import io_supply_pkg::*;
#(
    parameter int N_DOM      = 4,
    parameter int SETTLE_W   = 8,
    parameter int SETTLE_CYC = 200,
    parameter int TMO_CYC    = 1000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [N_DOM-1:0] pgood,
    output logic [N_DOM-1:0] en,
    output logic             ready,
    output logic             busy,
    output logic             fault,
    output logic [DOM_W-1:0] fault_dom
);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TMO_CYC - 1);
    localparam logic [DOM_W-1:0]    IDX_TOP     = DOM_W'(N_DOM - 1);

    state_e              state_q, state_d;
    logic [N_DOM-1:0]    en_q, en_d, pg_s;
    logic [DOM_W-1:0]    idx_q, idx_d, fdom_q, fdom_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                armed_q, armed_d;
    logic                pg_cur, settle_done;
`ifdef SUPPLY_SEQ_MON_EN
    logic [N_DOM-1:0]    mon_q, mon_d, pg_bad;
`endif

    io_sync2 #(.W(N_DOM)) u_pg_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (pgood),
        .q_o    (pg_s)
    );

    assign pg_cur      = |(pg_s & (N_DOM'(1) << idx_q));
    assign settle_done = (settle_q >= SETTLE_LAST);

`ifdef SUPPLY_SEQ_MON_EN
    // A domain is bad once its pgood has been low on two consecutive ON cycles.
    assign mon_d  = (state_q == S_ON) ? ~pg_s : '0;
    assign pg_bad = mon_q & ~pg_s;
`endif

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        idx_d    = idx_q;
        fdom_d   = fdom_q;
        settle_d = '0;
        tmo_d    = '0;
        armed_d  = 1'b0;
        unique case (state_q)
            S_OFF: begin
                if (start && !stop) begin
                    state_d = S_UP_WAIT;
                    idx_d   = '0;
                    en_d    = N_DOM'(1);
                end
            end
            S_UP_WAIT: begin
                if (stop) begin
                    state_d = S_DN_SETTLE;
                    en_d    = en_q >> 1;
                end else if (pg_cur) begin
                    state_d = S_UP_SETTLE;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = S_FAULT;
                    en_d    = '0;
                    fdom_d  = idx_q;
                end else begin
                    tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
                end
            end
            S_UP_SETTLE: begin
                if (stop) begin
                    state_d = S_DN_SETTLE;
                    en_d    = en_q >> 1;
                end else if (settle_done) begin
                    if (idx_q == IDX_TOP) begin
                        state_d = S_ON;
                    end else begin
                        state_d = S_UP_WAIT;
                        idx_d   = idx_q + 1'b1;
                        en_d    = (en_q << 1) | N_DOM'(1);
                    end
                end else begin
                    settle_d = (settle_q == '1) ? settle_q : settle_q + 1'b1;
                end
            end
            S_ON: begin
`ifdef SUPPLY_SEQ_MON_EN
                if (|pg_bad) begin
                    state_d = S_FAULT;
                    en_d    = '0;
                    for (int k = N_DOM - 1; k >= 0; k--) begin
                        if (pg_bad[k]) fdom_d = DOM_W'(k);
                    end
                end else
`endif
                if (stop) begin
                    state_d = S_DN_SETTLE;
                    idx_d   = IDX_TOP;
                    en_d    = en_q >> 1;
                end
            end
            S_DN_SETTLE: begin
                if (settle_done) begin
                    if (idx_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        idx_d = idx_q - 1'b1;
                        en_d  = en_q >> 1;
                    end
                end else begin
                    settle_d = (settle_q == '1) ? settle_q : settle_q + 1'b1;
                end
            end
            S_FAULT: begin
                // Leaving needs start seen low first, then high again.
                en_d    = '0;
                armed_d = armed_q | !start;
                if (armed_q && start) begin
                    state_d = S_OFF;
                    fdom_d  = '0;
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = S_OFF;
                en_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_OFF;
            en_q     <= '0;
            idx_q    <= '0;
            fdom_q   <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            armed_q  <= 1'b0;
`ifdef SUPPLY_SEQ_MON_EN
            mon_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            idx_q    <= idx_d;
            fdom_q   <= fdom_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            armed_q  <= armed_d;
`ifdef SUPPLY_SEQ_MON_EN
            mon_q    <= mon_d;
`endif
        end
    end

    assign en        = en_q;
    assign ready     = (state_q == S_ON);
    assign busy      = (state_q == S_UP_WAIT) || (state_q == S_UP_SETTLE) || (state_q == S_DN_SETTLE);
    assign fault     = (state_q == S_FAULT);
    assign fault_dom = fdom_q;
endmodule
